adc128s022_responder: RTL and testbench

//  Synthesizable SPI target emulating an ADC128S022 (8-ch, 12-bit, SPI mode 3) for the bench and FPGA loopback.

---
 rtl/adc128s022_responder.sv | 146 ++++++++++++++
 tb/tb_adc128s022_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc128s022_responder.sv
// SPI mode-3 target emulating an ADC128S022: decodes the control byte and returns the addressed channel one frame later.
// Optional control-byte sanity check builds when ADC128S022_RESPONDER_CTRL_CHECK_EN is defined.
module adc128s022_responder #(
    parameter int Sync_Stages     = 2,
    parameter int Default_Channel = 0
) (
    input  logic             clk,
    input  logic             async_rst_n,
    input  logic             clk_en,
    input  logic [7:0][11:0] channel_values,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             copi,
    output logic             cipo,
    output logic             cipo_en,
    output logic [2:0]       last_address,
    output logic             frame_done,
    output logic             frame_error,
    output logic             ctrl_warn
);
    localparam logic [2:0] DEF_CH = 3'(Default_Channel);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nxt;

    logic [Sync_Stages-1:0] sclk_sync, cs_sync, copi_sync;
    logic sclk_d, cs_d;
    logic sclk_s, cs_s, copi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [15:0] shift_reg;
    logic [7:0]  ctrl_reg;
    logic [3:0]  bit_cnt;
    logic        first_fall;
    logic        frame_end;
    logic [2:0]  load_idx;
    logic [15:0] load_val;

    // cs chain resets low so a cs_n still held low after reset is not taken as a
    // fresh select; the responder waits for a genuine falling edge.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            sclk_sync <= '1;
            cs_sync   <= '0;
            copi_sync <= '0;
            sclk_d    <= 1'b1;
            cs_d      <= 1'b0;
        end else if (clk_en) begin
            sclk_sync <= {sclk_sync[Sync_Stages-2:0], sclk};
            cs_sync   <= {cs_sync[Sync_Stages-2:0], cs_n};
            copi_sync <= {copi_sync[Sync_Stages-2:0], copi};
            sclk_d    <= sclk_sync[Sync_Stages-1];
            cs_d      <= cs_sync[Sync_Stages-1];
        end
    end

    assign sclk_s    = sclk_sync[Sync_Stages-1];
    assign cs_s      = cs_sync[Sync_Stages-1];
    assign copi_s    = copi_sync[Sync_Stages-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) state <= IDLE;
        else if (clk_en)  state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = ACTIVE;
            ACTIVE:  if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cipo_en   = (state == ACTIVE);
    assign frame_end = (state == ACTIVE) && !cs_rise && sclk_rise && (bit_cnt == 4'd15);
    // A fresh select always starts on the default channel; inside a burst the
    // channel comes from the frame just completed.
    assign load_idx  = (state == IDLE) ? DEF_CH : ctrl_reg[5:3];
    assign load_val  = {4'b0, channel_values[load_idx]};

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            shift_reg    <= '0;
            ctrl_reg     <= '0;
            bit_cnt      <= '0;
            first_fall   <= 1'b1;
            cipo         <= 1'b0;
            last_address <= '0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
        end else if (clk_en) begin
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            if (state == IDLE) begin
                if (cs_fall) begin
                    shift_reg  <= load_val;
                    cipo       <= load_val[15];
                    bit_cnt    <= '0;
                    first_fall <= 1'b1;
                end
            end else if (cs_rise) begin
                if (bit_cnt != 4'd0) frame_error <= 1'b1;
                bit_cnt <= '0;
            end else begin
                // The first fall of a frame presents the MSB already in place.
                if (sclk_fall) begin
                    if (first_fall) begin
                        first_fall <= 1'b0;
                        cipo       <= shift_reg[15];
                    end else begin
                        shift_reg <= {shift_reg[14:0], 1'b0};
                        cipo      <= shift_reg[14];
                    end
                end
                if (sclk_rise) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (!bit_cnt[3]) ctrl_reg <= {ctrl_reg[6:0], copi_s};
                    if (frame_end) begin
                        frame_done   <= 1'b1;
                        last_address <= ctrl_reg[5:3];
                        shift_reg    <= load_val;
                        cipo         <= load_val[15];
                        first_fall   <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef ADC128S022_RESPONDER_CTRL_CHECK_EN
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) ctrl_warn <= 1'b0;
        else if (clk_en)  ctrl_warn <= frame_end && (|{ctrl_reg[7:6], ctrl_reg[2:0]});
    end
`else
    logic ctrl_unused;
    assign ctrl_unused = ^{ctrl_reg[7:6], ctrl_reg[2:0]};
    assign ctrl_warn   = 1'b0;
`endif

endmodule

// File: tb/tb_adc128s022_responder.sv
// Randomised bench for adc128s022_responder: an SPI mode-3 initiator plus a frame-level channel model.
module tb_adc128s022_responder;
`ifdef ADC128S022_RESPONDER_CTRL_CHECK_EN
    localparam bit EXP_WARN = 1'b1;
`else
    localparam bit EXP_WARN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             async_rst_n = 1'b0;
    logic             clk_en = 1'b1;
    logic [7:0][11:0] channel_values = '0;
    logic             sclk = 1'b1;
    logic             cs_n = 1'b1;
    logic             copi = 1'b0;
    logic             cipo, cipo_en, frame_done, frame_error, ctrl_warn;
    logic [2:0]       last_address;

    int tests = 0;
    int fails = 0;
    int n_done = 0, n_err = 0, n_warn = 0;

    adc128s022_responder dut (
        .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
        .channel_values(channel_values), .sclk(sclk), .cs_n(cs_n), .copi(copi),
        .cipo(cipo), .cipo_en(cipo_en), .last_address(last_address),
        .frame_done(frame_done), .frame_error(frame_error), .ctrl_warn(ctrl_warn)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)  n_done++;
        if (frame_error) n_err++;
        if (ctrl_warn)   n_warn++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode 3 initiator: data changes on fall, both sides sample on rise; 40 clk sclk period.
    task automatic spi_bits(input logic [7:0] ctrl, input int first, input int nbits,
                            inout logic [15:0] rx);
        for (int i = first; i < first + nbits; i++) begin
            sclk = 1'b0;
            copi = (i < 8) ? ctrl[7-i] : 1'($urandom);
            tick(20);
            rx[15-i] = cipo;
            sclk = 1'b1;
            tick(20);
        end
    endtask

    task automatic test_reset;
        logic [15:0] rx;
        int d0, e0;
        tick(3);
        tests++; if (cipo !== 1'b0) begin fails++; $display("FAIL rst_cipo got %b want 0", cipo); end
        tests++; if (cipo_en !== 1'b0) begin fails++; $display("FAIL rst_cipo_en got %b want 0", cipo_en); end
        tests++; if (last_address !== 3'd0) begin fails++; $display("FAIL rst_last_address got %0d want 0", last_address); end
        tests++; if ({frame_done, frame_error, ctrl_warn} !== 3'b000) begin
            fails++; $display("FAIL rst_pulses got %b want 000", {frame_done, frame_error, ctrl_warn}); end
        async_rst_n = 1'b1;
        tick(5);
        channel_values[0] = 12'h5A3;
        channel_values[7] = 12'hFFF;
        cs_n = 1'b0; tick(10);
        tests++; if (cipo_en !== 1'b1) begin fails++; $display("FAIL sel_cipo_en got %b want 1", cipo_en); end
        rx = '0;
        spi_bits(8'h38, 0, 16, rx);
        rx = '0;
        spi_bits(8'h00, 0, 5, rx);
        sclk = 1'b0; tick(20);
        tests++; if (cipo !== 1'b1) begin fails++; $display("FAIL midframe_cipo got %b want 1", cipo); end
        async_rst_n = 1'b0; #1;
        tests++; if ({cipo, cipo_en, last_address} !== 5'b0) begin
            fails++; $display("FAIL async_rst got cipo=%b en=%b addr=%0d want 0", cipo, cipo_en, last_address); end
        tick(2);
        async_rst_n = 1'b1;
        d0 = n_done; e0 = n_err;
        spi_bits(8'h38, 0, 4, rx);
        tests++; if (cipo_en !== 1'b0 || n_done != d0) begin
            fails++; $display("FAIL post_rst_ignored got en=%b done=%0d want en=0 done=%0d", cipo_en, n_done, d0); end
        tick(10); cs_n = 1'b1; tick(10);
        tests++; if (n_err != e0) begin fails++; $display("FAIL post_rst_err got %0d want %0d", n_err, e0); end
        cs_n = 1'b0; tick(10);
        rx = '0;
        spi_bits(8'h00, 0, 16, rx);
        tests++; if (rx !== {4'b0, channel_values[0]}) begin fails++; $display("FAIL post_rst_frame got %h want %h", rx, {4'b0, channel_values[0]}); end
        cs_n = 1'b1; tick(20);
    endtask

    task automatic test_single;
        logic [15:0] rx;
        int d0, e0;
        channel_values[0] = 12'hABC;
        channel_values[5] = 12'h123;
        d0 = n_done; e0 = n_err;
        cs_n = 1'b0; tick(10);
        rx = '0;
        spi_bits(8'h28, 0, 16, rx);
        tests++; if (rx !== 16'h0ABC) begin fails++; $display("FAIL single_rx got %h want 0abc", rx); end
        tests++; if (last_address !== 3'd5) begin fails++; $display("FAIL single_addr got %0d want 5", last_address); end
        tests++; if (n_done - d0 != 1 || n_err != e0) begin
            fails++; $display("FAIL single_pulses got done=%0d err=%0d want 1 0", n_done - d0, n_err - e0); end
        cs_n = 1'b1; tick(10);
        tests++; if (cipo_en !== 1'b0) begin fails++; $display("FAIL desel_cipo_en got %b want 0", cipo_en); end
        cs_n = 1'b0; tick(10);
        rx = '0;
        spi_bits(8'h00, 0, 16, rx);
        tests++; if (rx !== 16'h0ABC) begin fails++; $display("FAIL reselect_rx got %h want 0abc", rx); end
        cs_n = 1'b1; tick(20);
    endtask

    task automatic test_burst;
        logic [15:0] rx;
        logic [7:0]  ctrl;
        logic [2:0]  m_next;
        int d0, w0, bad, nframes;
        for (int i = 0; i < 8; i++) channel_values[i] = 12'(16'h100 * i + i);
        d0 = n_done; bad = 0; m_next = 3'd0;
        cs_n = 1'b0; tick(10);
        for (int k = 0; k < 8; k++) begin
            ctrl = {2'b00, 3'((k + 1) % 8), 3'b000};
            rx = '0;
            spi_bits(ctrl, 0, 16, rx);
            tests++; if (rx !== {4'b0, channel_values[m_next]}) begin
                fails++; $display("FAIL burst_rx frame %0d got %h want %h", k, rx, {4'b0, channel_values[m_next]}); end
            m_next = ctrl[5:3];
        end
        cs_n = 1'b1; tick(20);
        tests++; if (n_done - d0 != 8) begin fails++; $display("FAIL burst_done got %0d want 8", n_done - d0); end
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) channel_values[i] = 12'($urandom);
            nframes = $urandom_range(1, 4);
            m_next = 3'd0;
            cs_n = 1'b0; tick(10);
            for (int k = 0; k < nframes; k++) begin
                ctrl = 8'($urandom);
                w0 = n_warn;
                rx = '0;
                spi_bits(ctrl, 0, 16, rx);
                bad = (EXP_WARN && (ctrl & 8'hC7) != 0) ? 1 : 0;
                tests++; if (rx !== {4'b0, channel_values[m_next]} || last_address !== ctrl[5:3] || n_warn - w0 != bad) begin
                    fails++; $display("FAIL rand_frame b%0d f%0d got rx=%h addr=%0d warn=%0d want rx=%h addr=%0d warn=%0d",
                                      b, k, rx, last_address, n_warn - w0, {4'b0, channel_values[m_next]}, ctrl[5:3], bad); end
                m_next = ctrl[5:3];
            end
            cs_n = 1'b1; tick(20);
        end
    endtask

    task automatic test_abort;
        logic [15:0] rx;
        int d0, e0;
        for (int i = 0; i < 8; i++) channel_values[i] = 12'($urandom);
        d0 = n_done; e0 = n_err;
        cs_n = 1'b0; tick(10);
        rx = '0;
        spi_bits(8'h18, 0, 16, rx);
        spi_bits(8'h30, 0, 9, rx);
        cs_n = 1'b1; tick(10);
        tests++; if (n_err - e0 != 1) begin fails++; $display("FAIL abort_err got %0d want 1", n_err - e0); end
        tests++; if (last_address !== 3'd3 || n_done - d0 != 1) begin
            fails++; $display("FAIL abort_addr got addr=%0d done=%0d want 3 1", last_address, n_done - d0); end
        e0 = n_err;
        cs_n = 1'b0; tick(10);
        rx = '0;
        spi_bits(8'h00, 0, 16, rx);
        tests++; if (rx !== {4'b0, channel_values[0]}) begin fails++; $display("FAIL abort_next got %h want %h", rx, {4'b0, channel_values[0]}); end
        cs_n = 1'b1; tick(10);
        tests++; if (n_err != e0) begin fails++; $display("FAIL clean_end_err got %0d want 0", n_err - e0); end
        tick(10);
    endtask

    task automatic test_ctrl_warn;
        logic [15:0] rx;
        int w0;
        channel_values[5] = 12'h3C5;
        w0 = n_warn;
        cs_n = 1'b0; tick(10);
        rx = '0;
        spi_bits(8'h29, 0, 16, rx);
        tests++; if (n_warn - w0 != int'(EXP_WARN) || last_address !== 3'd5) begin
            fails++; $display("FAIL warn_frame got warn=%0d addr=%0d want %0d 5", n_warn - w0, last_address, EXP_WARN); end
        w0 = n_warn;
        rx = '0;
        spi_bits(8'h28, 0, 16, rx);
        tests++; if (rx !== 16'h03C5 || n_warn != w0) begin
            fails++; $display("FAIL warn_next got rx=%h warn=%0d want 03c5 0", rx, n_warn - w0); end
        cs_n = 1'b1; tick(20);
    endtask

    task automatic test_channel_change;
        logic [15:0] rx, exp0;
        logic [11:0] new2;
        for (int i = 0; i < 8; i++) channel_values[i] = 12'($urandom);
        exp0 = {4'b0, channel_values[0]};
        new2 = 12'($urandom);
        cs_n = 1'b0; tick(10);
        rx = '0;
        spi_bits(8'h10, 0, 8, rx);
        channel_values[0] = ~channel_values[0];
        channel_values[2] = new2;
        spi_bits(8'h10, 8, 8, rx);
        tests++; if (rx !== exp0) begin fails++; $display("FAIL midframe_change got %h want %h", rx, exp0); end
        rx = '0;
        spi_bits(8'h00, 0, 16, rx);
        tests++; if (rx !== {4'b0, new2}) begin fails++; $display("FAIL load_time_value got %h want %h", rx, {4'b0, new2}); end
        cs_n = 1'b1; tick(20);
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_abort();
        test_ctrl_warn();
        test_channel_change();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
